// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB master arbiter.
//   apb_state_e      - transfer FSM state encoding (IDLE/SETUP/ACCESS)
//   DEF_*            - default width / timeout constants used as parameter defaults
//   NUM_REQ          - number of requesters served by the arbiter
//   idx_to_onehot()  - converts a requester index into a one-hot vector
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 8;
    localparam int NUM_REQ        = 2;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, purely combinational.
//   req  - request vector (bit per requester)
//   last - index of the requester granted most recently
//   gnt  - one-hot grant (all zero when nothing is requested)
// A lone request always wins; on contention the requester that was not
// granted last wins.
module rr_arbiter2
    import apb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = idx_to_onehot(~last);
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between two requesters.
//   pclk, presetn               - clock, asynchronous active-low reset
//   req_valid/write/addr/wdata  - per-requester transfer requests (requester 0 in low bits)
//   req_accept                  - one-cycle one-hot pulse during SETUP of the granted request
//   rsp_valid/rsp_rdata/rsp_err - one-cycle completion pulse with read data and error flag
//   psel/penable/pwrite/paddr/pwdata, pready/prdata/pslverr - APB master side
// A transfer is IDLE -> SETUP -> ACCESS (one or more cycles) -> IDLE. An
// ACCESS phase that sees pready low for TIMEOUT cycles is aborted and
// reported as an error. Every output is a register.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
)(
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_accept,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    // Counter value reached on the last allowed wait cycle; the next
    // pready-low ACCESS cycle at this value is the TIMEOUT-th one.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    apb_state_e            state_reg;
    logic                  grant_reg;
    logic                  last_reg;
    logic [7:0]            wait_cnt_reg;
    logic [1:0]            gnt;
    logic                  gnt_idx;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    // Unpack the flat request buses so the granted fields can be picked by index.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter2 u_arb (
        .req  (req_valid),
        .last (last_reg),
        .gnt  (gnt)
    );

    assign gnt_idx = gnt[1];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg    <= IDLE;
            grant_reg    <= 1'b0;
            last_reg     <= 1'b1;   // requester 0 wins the first contention
            wait_cnt_reg <= '0;
            psel         <= 1'b0;
            penable      <= 1'b0;
            pwrite       <= 1'b0;
            paddr        <= '0;
            pwdata       <= '0;
            req_accept   <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            req_accept <= '0;
            rsp_valid  <= '0;
            case (state_reg)
                IDLE: begin
                    // Requests are only looked at here, so changes while a
                    // transfer is in flight are simply held until we return.
                    if (|req_valid) begin
                        state_reg    <= SETUP;
                        grant_reg    <= gnt_idx;
                        last_reg     <= gnt_idx;
                        wait_cnt_reg <= '0;
                        req_accept   <= gnt;
                        psel         <= 1'b1;
                        penable      <= 1'b0;
                        pwrite       <= req_write[gnt_idx];
                        paddr        <= addr_arr[gnt_idx];
                        pwdata       <= wdata_arr[gnt_idx];
                    end
                end
                SETUP: begin
                    state_reg <= ACCESS;
                    penable   <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        state_reg <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= idx_to_onehot(grant_reg);
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? '0 : prdata;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        // Completer never answered: abort with an error.
                        state_reg <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= idx_to_onehot(grant_reg);
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scenarios followed by random traffic.
// The driver process keeps a transaction-level model (round-robin choice,
// transfer length = SETUP + ACCESS cycles computed from the completer's wait
// count and the timeout) and pushes the expected response of every accepted
// request into a scoreboard; a separate monitor pops and compares whenever
// rsp_valid pulses.
module tb_apb_master_arbiter;

    localparam int TO = 8;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_accept;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    apb_master_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_accept(req_accept), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    initial forever #5 pclk = ~pclk;

    typedef struct { int w; logic err; logic [31:0] rd; } cpl_t;
    typedef struct { int id; logic err; logic [31:0] rdata; int pen; } rsp_t;

    int   total = 0;
    int   bad = 0;
    cpl_t cpl_q[$];
    rsp_t sb[$];
    int   grant_log[$];

    // reference model state
    int          busy = 0;       // cycles until the transfer in flight ends (0 = idle)
    int          len_cur = 0;    // ACCESS cycles of the current transfer
    int          w_cur = 0;      // completer wait cycles before pready
    logic        err_cur = 1'b0;
    logic [31:0] rd_cur = '0;
    logic        model_last = 1'b1;
    logic        exp_wr = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    int          gen_pct = 0;    // chance (out of 4) an idle requester raises a request

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid[i]          = 1'b1;
        req_write[i]          = wr;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic model_reset();
        busy = 0; model_last = 1'b1;
        exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
        req_valid = '0;
        sb.delete(); cpl_q.delete();
    endtask

    // One clock: sample-side checks against the model, then drive next inputs.
    task automatic step();
        logic [1:0] vs, exp_acc;
        logic       ep, ee, er, in_acc;
        int         g, k;
        cpl_t       c;
        rsp_t       e;
        vs = req_valid;
        @(posedge pclk); #1;
        exp_acc = '0; ep = 1'b0; ee = 1'b0; er = 1'b0; in_acc = 1'b0;
        if (busy == 0) begin
            if (vs != 2'b00) begin
                g = (vs == 2'b11) ? (model_last ? 0 : 1) : (vs[1] ? 1 : 0);
                exp_acc    = (g == 1) ? 2'b10 : 2'b01;
                model_last = g[0];
                exp_wr     = req_write[g];
                exp_addr   = req_addr[g*32 +: 32];
                exp_wdata  = req_wdata[g*32 +: 32];
                if (cpl_q.size() > 0) c = cpl_q.pop_front();
                else begin
                    c.w   = $urandom_range(0, TO + 2);
                    c.err = ($urandom_range(0, 4) == 0);
                    c.rd  = $urandom;
                end
                w_cur = c.w; err_cur = c.err; rd_cur = c.rd;
                len_cur = (c.w < TO) ? c.w + 1 : TO;
                busy = len_cur + 1;
                e.id    = g;
                e.err   = (c.w >= TO) || c.err;
                e.rdata = ((c.w >= TO) || exp_wr) ? 32'h0 : c.rd;
                e.pen   = len_cur;
                sb.push_back(e);
                req_valid[g] = 1'b0;
                ep = 1'b1;
            end
        end else begin
            busy--;
            in_acc = (busy > 0);
            ep = in_acc; ee = in_acc; er = (busy == 0);
        end
        check("bus_phase", 128'({psel, penable, req_accept, |rsp_valid}), 128'({ep, ee, exp_acc, er}));
        check("apb_fields", 128'({pwrite, paddr, pwdata}), 128'({exp_wr, exp_addr, exp_wdata}));
        if (req_accept != 2'b00) grant_log.push_back(req_accept[1] ? 1 : 0);
        // completer for the next edge
        if (in_acc) begin
            k = len_cur - busy;
            if (k == w_cur) begin
                pready = 1'b1; pslverr = err_cur; prdata = rd_cur;
            end else begin
                pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
            end
        end else begin
            pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
        end
        // requesters
        for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] && gen_pct > 0 && $urandom_range(1, 4) <= gen_pct)
                set_req(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, $urandom);
        end
    endtask

    task automatic run_until_idle(input int maxc);
        int n = 0;
        while ((busy != 0 || req_valid != 2'b00) && n < maxc) begin
            step();
            n++;
        end
        if (busy != 0 || req_valid != 2'b00) begin
            total++; bad++;
            $display("FAIL idle_wait: busy=%0d req_valid=%b after %0d cycles, required idle", busy, req_valid, n);
        end
        repeat (2) step();
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 128'({psel, penable, pwrite, paddr, pwdata, req_accept, rsp_valid, rsp_rdata, rsp_err}), 128'(0));
    endtask

    // monitor / scoreboard
    initial begin
        int   pen_cnt = 0;
        int   nrsp = 0;
        rsp_t e;
        forever begin
            @(negedge pclk);
            if (!presetn) pen_cnt = 0;
            else begin
                if (penable) pen_cnt++;
                if (rsp_valid != 2'b00) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rsp_unexpected: got rsp_valid=%b expected none", rsp_valid);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", 128'(rsp_valid), 128'((e.id == 1) ? 2'b10 : 2'b01));
                        check("rsp_err", 128'(rsp_err), 128'(e.err));
                        check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
                        check("penable_cycles", 128'(pen_cnt), 128'(e.pen));
                        $display("rsp %0d: id=%0d err=%0b rdata=%08h penable_cycles=%0d",
                                 nrsp, e.id, rsp_err, rsp_rdata, pen_cnt);
                        nrsp++;
                    end
                    pen_cnt = 0;
                end
            end
        end
    end

    initial begin
        int   n;
        cpl_t c;
        // reset state
        repeat (3) @(posedge pclk);
        #1;
        check_reset_outputs("reset_state");
        model_reset();
        presetn = 1'b1;
        repeat (2) step();

        // req0 write, zero wait
        set_req(0, 1'b1, 32'h04, 32'hDEADBEEF);
        c.w = 0; c.err = 1'b0; c.rd = 32'h5555AAAA; cpl_q.push_back(c);
        run_until_idle(40);
        // req1 read, 3 wait cycles
        set_req(1, 1'b0, 32'h08, 32'h0);
        c.w = 3; c.err = 1'b0; c.rd = 32'h12345678; cpl_q.push_back(c);
        run_until_idle(40);
        // slave error on a read
        set_req(0, 1'b0, 32'h10, 32'h0);
        c.w = 0; c.err = 1'b1; c.rd = 32'h0BADF00D; cpl_q.push_back(c);
        run_until_idle(40);
        // pready stuck low -> timeout abort
        set_req(1, 1'b1, 32'h0C, 32'h11112222);
        c.w = 255; c.err = 1'b0; c.rd = 32'hFFFFFFFF; cpl_q.push_back(c);
        run_until_idle(40);
        // pready on the last allowed cycle completes normally
        set_req(0, 1'b0, 32'h14, 32'h0);
        c.w = TO - 1; c.err = 1'b0; c.rd = 32'hCAFEF00D; cpl_q.push_back(c);
        run_until_idle(40);

        // reset in the middle of ACCESS: everything clears, no response
        set_req(1, 1'b1, 32'h20, 32'hA5A5A5A5);
        c.w = 255; c.err = 1'b0; c.rd = 32'h0; cpl_q.push_back(c);
        repeat (4) step();
        #2 presetn = 1'b0;
        #1 check_reset_outputs("reset_mid_access");
        model_reset();
        repeat (2) begin
            @(posedge pclk); #1;
            check("reset_hold", 128'({psel, penable, rsp_valid}), 128'(0));
        end
        presetn = 1'b1;
        repeat (2) step();

        // both requesters continuously valid: strict alternation from requester 0
        grant_log.delete();
        gen_pct = 4;
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin
            step();
            n++;
        end
        gen_pct = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("grant_order", 128'(grant_log[i]), 128'(i % 2));
            else begin
                total++; bad++;
                $display("FAIL grant_order: got only %0d grants, required 4", grant_log.size());
            end
        end
        run_until_idle(100);

        // random traffic
        gen_pct = 1;
        repeat (3000) step();
        gen_pct = 0;
        run_until_idle(200);
        repeat (3) step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d outstanding responses, required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 8, maximum ACCESS cycles before abort (range 2..255).
REQ-004 SHALL have port pclk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port presetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  2  per-requester transfer request, held until accepted.
REQ-007 SHALL have port req_write  input  2  per-requester direction (1 write, 0 read).
REQ-008 SHALL have port req_addr  input  2*ADDR_WIDTH  packed addresses, requester 0 in low bits.
REQ-009 SHALL have port req_wdata  input  2*DATA_WIDTH  packed write data, requester 0 in low bits.
REQ-010 SHALL have port req_accept  output  2  one-cycle one-hot pulse, request captured.
REQ-011 SHALL have port rsp_valid  output  2  one-cycle one-hot pulse, transfer complete.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, qualified by rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-014 SHALL have ports psel, penable, pwrite (output 1), paddr (output ADDR_WIDTH), pwdata (output DATA_WIDTH): APB master side.
REQ-015 SHALL have ports pready (input 1), prdata (input DATA_WIDTH), pslverr (input 1): APB completer response.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-017 IDLE: if any req_valid sampled high, SHALL grant one requester, capture its write/addr/wdata, go to SETUP; else stay IDLE.
REQ-018 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; single valid always granted.
REQ-019 req_accept[g] SHALL be high exactly during the SETUP cycle; requester g then deasserts req_valid.
REQ-020 SETUP: psel=1, penable=0, paddr/pwrite/pwdata = captured values; unconditionally go to ACCESS next cycle.
REQ-021 ACCESS: psel=1, penable=1, paddr/pwrite/pwdata stable; on pready=1 go to IDLE.
REQ-022 On pready=1 in ACCESS, next cycle SHALL pulse rsp_valid[g], rsp_err=pslverr, rsp_rdata=prdata for reads and 0 for writes.
REQ-023 Zero-wait latency: req_valid sampled at edge N -> SETUP at N+1 -> ACCESS at N+2 -> rsp_valid at N+3; no back-to-back transfers, psel low at least one cycle between.
REQ-024 Wait counter SHALL count ACCESS cycles with pready=0; on TIMEOUT-th such cycle, abort: go to IDLE, pulse rsp_valid[g], rsp_err=1, rsp_rdata=0.
REQ-025 Wait counter SHALL clear on every entry into SETUP.
REQ-026 req_valid changes outside IDLE SHALL be ignored; no request lost if held.
REQ-027 In IDLE: psel=0, penable=0; paddr/pwdata/pwrite hold last values.

Reset
REQ-028 presetn low SHALL immediately force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_accept=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
REQ-029 Reset SHALL set last-grant to requester 1 so requester 0 wins first contention.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no rsp_valid pulse.

Structure
REQ-031 Package apb_pkg SHALL hold FSM state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and default width constants.
REQ-032 Round-robin grant logic SHALL be sub-module rr_arbiter2 (inputs req[1:0], last; output one-hot gnt).

Verification
REQ-033 Req0 write addr 0x04 data 0xDEADBEEF, pready=1 -> accept[0] at N+1, psel/penable correct, rsp_valid[0] at N+3, rsp_err=0.
REQ-034 Req1 read addr 0x08, pready low 3 cycles, prdata=0x12345678 -> penable high 4 cycles, rsp_rdata=0x12345678.
REQ-035 Both valid continuously, 4 transfers after reset -> grant order 0,1,0,1.
REQ-036 TIMEOUT=8, pready stuck 0 -> penable high exactly 8 cycles, rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-037 pslverr=1 with pready=1 -> rsp_err=1; presetn low during ACCESS -> all outputs 0 same cycle, no rsp_valid.
